// File: rtl/banked_ram_pkg.sv
// Shared types and default geometry for the banked burst RAM.
// No logic; widths here are the default build, modules re-derive from their own parameters.
// No flow control.
package banked_ram_pkg;
    localparam int DEF_ADDR_WIDTH  = 14;
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_LANE_WIDTH  = 8;
    localparam int DEF_NUM_BANKS   = 4;
    localparam int DEF_BURST_WIDTH = 4;

    localparam int NUM_LANES = DEF_DATA_WIDTH / DEF_LANE_WIDTH;
    localparam int BANK_BITS = $clog2(DEF_NUM_BANKS);
    localparam int ROW_WIDTH = DEF_ADDR_WIDTH - BANK_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;
endpackage

// File: rtl/bank_ram.sv
// One RAM bank: per-lane write enables, optional per-lane even parity (RAM_PARITY_EN).
// Latency: read data and parity error registered 1 cycle after en & ~we.
// Backpressure: none; read register holds its value until the next read.
module bank_ram #(
    parameter int ROW_WIDTH  = 12,
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                we,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0]    be,
    input  logic [ROW_WIDTH-1:0]                row,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH-1:0]               rdata,
    output logic                                perr
);
    localparam int N_LANES = DATA_WIDTH / LANE_WIDTH;

    logic [DATA_WIDTH-1:0] mem [2**ROW_WIDTH];
    logic [DATA_WIDTH-1:0] rword;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd;

    assign rd    = en & ~we;
    assign rword = mem[row];

    always_comb begin
        wmask = '0;
        for (int l = 0; l < N_LANES; l++) begin
            wmask[l*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{be[l]}};
        end
    end

    // Storage is never reset; disabled lanes keep their old contents.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[row] <= (rword & ~wmask) | (wdata & wmask);
        end
    end

    always_comb begin
        rdata_d = rd ? rword : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

`ifdef RAM_PARITY_EN
    logic [N_LANES-1:0] par_mem [2**ROW_WIDTH];
    logic [N_LANES-1:0] wpar, rpar, spar;
    logic               perr_q, perr_d;

    assign spar = par_mem[row];

    always_comb begin
        wpar = '0;
        rpar = '0;
        for (int l = 0; l < N_LANES; l++) begin
            wpar[l] = ^wdata[l*LANE_WIDTH +: LANE_WIDTH];
            rpar[l] = ^rword[l*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (en && we) begin
            par_mem[row] <= (spar & ~be) | (wpar & be);
        end
    end

    always_comb begin
        perr_d = rd ? |(rpar ^ spar) : perr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif
endmodule

// File: rtl/banked_sync_ram.sv
// Multi-bank RAM with read/write burst engine; optional lane parity via RAM_PARITY_EN.
// Latency: read beat on rdata one cycle after issue; one beat per cycle in RD.
// Backpressure: req_ready only in IDLE; write beats stall on wdata_valid; reads have none.
module banked_sync_ram
    import banked_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int LANE_WIDTH  = DEF_LANE_WIDTH,
    parameter int NUM_BANKS   = DEF_NUM_BANKS,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [BURST_WIDTH-1:0]           req_len,
    input  logic [DATA_WIDTH/LANE_WIDTH-1:0] req_be,
    input  logic                             wdata_valid,
    output logic                             wdata_ready,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic                             rdata_valid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rdata_last,
    output logic                             busy,
    output logic                             par_err
);
    localparam int N_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int B_BITS  = $clog2(NUM_BANKS);
    localparam int R_WIDTH = ADDR_WIDTH - B_BITS;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BURST_WIDTH-1:0] len_q, len_d;
    logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_LANES-1:0]     be_q, be_d;
    logic [B_BITS-1:0]      sel_q, sel_d;
    logic                   rvld_q, rvld_d;
    logic                   rlast_q, rlast_d;

    logic                   active, bank_we, last_beat;
    logic [B_BITS-1:0]      bank_idx;
    logic [R_WIDTH-1:0]     row;
    logic [NUM_BANKS-1:0]   bank_oh;
    logic [NUM_BANKS-1:0]   bank_perr;
    logic [DATA_WIDTH-1:0]  bank_rdata [NUM_BANKS];

    assign bank_idx  = addr_q[ADDR_WIDTH-1 -: B_BITS];
    assign row       = addr_q[R_WIDTH-1:0];
    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        be_d    = be_q;
        sel_d   = sel_q;
        rvld_d  = 1'b0;
        rlast_d = 1'b0;
        active  = 1'b0;
        bank_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    be_d    = req_be;
                    cnt_d   = '0;
                    state_d = req_we ? WR : RD;
                end
            end
            RD: begin
                active  = 1'b1;
                sel_d   = bank_idx;
                rvld_d  = 1'b1;
                rlast_d = last_beat;
            end
            WR: begin
                active  = wdata_valid;
                bank_we = wdata_valid;
            end
            default: state_d = IDLE;
        endcase
        // Address wraps naturally at 2^ADDR_WIDTH and walks across banks.
        if (active) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            cnt_d  = cnt_q + BURST_WIDTH'(1);
            if (last_beat) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
            sel_q   <= '0;
            rvld_q  <= 1'b0;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            be_q    <= be_d;
            sel_q   <= sel_d;
            rvld_q  <= rvld_d;
            rlast_q <= rlast_d;
        end
    end

    assign bank_oh = active ? (NUM_BANKS'(1) << bank_idx) : '0;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        bank_ram #(
            .ROW_WIDTH  (R_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .LANE_WIDTH (LANE_WIDTH)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bank_oh[b]),
            .we    (bank_we),
            .be    (be_q),
            .row   (row),
            .wdata (wdata),
            .rdata (bank_rdata[b]),
            .perr  (bank_perr[b])
        );
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign wdata_ready = (state_q == WR);
    assign rdata_valid = rvld_q;
    assign rdata_last  = rlast_q;
    assign rdata       = bank_rdata[sel_q];
    assign par_err     = rvld_q & bank_perr[sel_q];
endmodule

// File: tb/tb_banked_sync_ram.sv
// Directed + randomized bench for banked_sync_ram against an associative-array memory model.
// Parity expectations follow RAM_PARITY_EN.
module tb_banked_sync_ram;
    import banked_ram_pkg::*;

    localparam logic [13:0] BANK_SPAN = 14'(1 << ROW_WIDTH);
    localparam int          NB        = 1 << BANK_BITS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [13:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [1:0]  req_be = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [15:0] wdata = '0;
    logic        rdata_valid;
    logic [15:0] rdata;
    logic        rdata_last;
    logic        busy;
    logic        par_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [logic [13:0]];
    logic [15:0] wbuf [16];

    banked_sync_ram dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .req_be      (req_be),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .rdata_last  (rdata_last),
        .busy        (busy),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input logic [13:0] a, input logic [1:0] be,
                                        input logic [15:0] d);
        logic [15:0] w;
        w = ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (be[l]) w[l*8 +: 8] = d[l*8 +: 8];
        end
        ref_mem[a] = w;
    endfunction

    task automatic do_req(input logic we, input logic [13:0] addr, input logic [3:0] len,
                          input logic [1:0] be);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("req_ready_timeout", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        req_be    = be;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_busy", 32'(busy), 32'd1);
    endtask

    task automatic write_burst(input logic [13:0] addr, input logic [3:0] len,
                               input logic [1:0] be, input bit gaps);
        do_req(1'b1, addr, len, be);
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                wdata_valid = 1'b0;
                @(negedge clk);
                chk("wr_gap_ready", 32'(wdata_ready), 32'd1);
            end
            wdata_valid = 1'b1;
            wdata       = wbuf[i];
            chk("wr_ready", 32'(wdata_ready), 32'd1);
            @(negedge clk);
            model_write(14'(addr + 14'(i)), be, wbuf[i]);
        end
        wdata_valid = 1'b0;
        chk("wr_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic read_burst(input logic [13:0] addr, input logic [3:0] len,
                              input logic exp_perr);
        logic [13:0] a;
        do_req(1'b0, addr, len, 2'b00);
        chk("rd_not_early", 32'(rdata_valid), 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            a = 14'(addr + 14'(i));
            chk("rd_valid", 32'(rdata_valid), 32'd1);
            chk("rd_data", 32'(rdata), 32'(ref_mem[a]));
            chk("rd_last", 32'(rdata_last), 32'(i == int'(len)));
            chk("rd_perr", 32'(par_err), 32'(exp_perr));
        end
        chk("rd_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
    endtask

    logic [13:0] bases [2];
    logic [13:0] a_r;
    logic [3:0]  len_r;
    logic        exp_par;

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat and hold
        wbuf[0] = 16'hBEEF;
        write_burst(14'h0005, 4'd0, 2'b11, 1'b0);
        read_burst(14'h0005, 4'd0, 1'b0);
        @(negedge clk);
        chk("rdata_hold_valid", 32'(rdata_valid), 32'd0);
        chk("rdata_hold_data", 32'(rdata), 32'h0000BEEF);

        // Lane enable
        wbuf[0] = 16'h1234;
        write_burst(14'h0005, 4'd0, 2'b01, 1'b0);
        read_burst(14'h0005, 4'd0, 1'b0);
        chk("lane_model", 32'(ref_mem[14'h0005]), 32'h0000BE34);

        // All lanes disabled: handshake only
        wbuf[0] = 16'h5A5A;
        write_burst(14'h0005, 4'd0, 2'b00, 1'b0);
        read_burst(14'h0005, 4'd0, 1'b0);

        // Bank crossing and address wrap
        for (int i = 0; i < 4; i++) wbuf[i] = 16'(i + 1);
        write_burst(BANK_SPAN - 14'd2, 4'd3, 2'b11, 1'b1);
        read_burst(BANK_SPAN - 14'd2, 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) wbuf[i] = 16'h7700 + 16'(i);
        write_burst(14'h3FFF, 4'd3, 2'b11, 1'b1);
        read_burst(14'h3FFF, 4'd3, 1'b0);
        chk("wrap_model", 32'(ref_mem[14'h0000]), 32'h00007701);

        // Reset in the middle of a read burst
        for (int i = 0; i < 8; i++) wbuf[i] = 16'hA000 + 16'(i);
        write_burst(14'h2000, 4'd7, 2'b11, 1'b0);
        do_req(1'b0, 14'h2000, 4'd7, 2'b00);
        @(negedge clk);
        chk("mid_beat0", 32'(rdata), 32'h0000A000);
        @(negedge clk);
        chk("mid_beat1", 32'(rdata), 32'h0000A001);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rdata_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(rdata_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        read_burst(14'h2000, 4'd7, 1'b0);

        // Parity: corrupt stored data bit 0 behind the design's back
        wbuf[0] = 16'h00FF;
        write_burst(14'h00A0, 4'd0, 2'b11, 1'b0);
        dut.g_bank[0].u_bank.mem[12'h0A0] = dut.g_bank[0].u_bank.mem[12'h0A0] ^ 16'h0001;
        ref_mem[14'h00A0] = ref_mem[14'h00A0] ^ 16'h0001;
`ifdef RAM_PARITY_EN
        exp_par = 1'b1;
`else
        exp_par = 1'b0;
`endif
        read_burst(14'h00A0, 4'd0, exp_par);

        // Randomized traffic in windows straddling a bank boundary and the wrap point
        bases[0] = 14'((NB / 2) * int'(BANK_SPAN) - 16);
        bases[1] = 14'h3FF0;
        for (int b = 0; b < 2; b++) begin
            fill_random();
            write_burst(bases[b], 4'd15, 2'b11, 1'b0);
            fill_random();
            write_burst(14'(bases[b] + 14'd16), 4'd15, 2'b11, 1'b1);
            for (int k = 0; k < 12; k++) begin
                a_r   = 14'(bases[b] + 14'($urandom_range(0, 15)));
                len_r = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) begin
                    fill_random();
                    write_burst(a_r, len_r, 2'($urandom_range(0, 3)), 1'b1);
                end else begin
                    read_burst(a_r, len_r, 1'b0);
                end
            end
            read_burst(bases[b], 4'd15, 1'b0);
            read_burst(14'(bases[b] + 14'd16), 4'd15, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
